regfile_sb: RTL and testbench



---
 rtl/regfile_sb_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 30 +++
 rtl/regfile_sb.sv | 69 ++++++
 tb/tb_regfile_sb.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared state encoding and defaults for the scoreboarded register file
package regfile_sb_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam int REG_ZERO = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, issue-set beats writeback-clear
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_all_i,
  input  logic                 set_en_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  input  logic                 clr_en_i,
  input  logic [ADDR_W-1:0]    clr_addr_i,
  output logic [2**ADDR_W-1:0] pend_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] pend_q, pend_d;
  // next pending vector: clear-all, then set, then writeback clear; entry 0 never pends
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++)
      pend_d[i] = (i == REG_ZERO || clr_all_i) ? 1'b0 :
                  (set_en_i && set_addr_i == ADDR_W'(i)) ? 1'b1 :
                  (clr_en_i && clr_addr_i == ADDR_W'(i)) ? 1'b0 : pend_q[i];
  end
  // pending register, emptied by active-low reset
  always_ff @(posedge clk)
    pend_q <= !rst ? '0 : pend_d;
  assign pend_o = pend_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with x0, write bypass, pending scoreboard and sweep clear
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     clear_req,
  output logic                     ready
);
  localparam int DEPTH = 2**ADDR_W;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend;
  logic run, upd;
  assign run = state_q == ST_RUN;
  assign upd = run && !clear_req;
  assign ready = run;
  // sweep advances one entry per cycle and hands over to RUN after the last entry
  always_comb begin
    state_d = run ? (clear_req ? ST_CLEAR : ST_RUN) :
              (clr_ptr_q == ADDR_W'(DEPTH-1) ? ST_RUN : ST_CLEAR);
    clr_ptr_d = run ? ADDR_W'(1) : clr_ptr_q + ADDR_W'(1);
  end
  // FSM state and sweep pointer, restarted by active-low reset
  always_ff @(posedge clk) begin
    state_q <= !rst ? ST_CLEAR : state_d;
    clr_ptr_q <= !rst ? ADDR_W'(1) : clr_ptr_d;
  end
  // array: sweep zeroes one entry per cycle, RUN accepts writebacks except to x0
  always_ff @(posedge clk) begin
    if (rst && !run)
      regs_q[clr_ptr_q] <= '0;
    else if (rst && upd && wr_en && wr_addr != ADDR_W'(REG_ZERO))
      regs_q[wr_addr] <= wr_data;
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .clr_all_i  (!run || clear_req),
    .set_en_i   (upd && iss_en),
    .set_addr_i (iss_addr),
    .clr_en_i   (upd && wr_en),
    .clr_addr_i (wr_addr),
    .pend_o     (pend)
  );
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic byp, zero;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign zero = !run || a == ADDR_W'(REG_ZERO);
    assign byp = BYPASS != 0 && wr_en && wr_addr == a;
    assign rd_data[g*DATA_W +: DATA_W] = zero ? '0 : byp ? wr_data : regs_q[a];
    assign rd_pending[g] = !zero && !byp && pend[a];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: random and directed checks of regfile_sb (BYPASS=1 and BYPASS=0) against a reference model
module tb_regfile_sb;
  logic clk = 0;
  logic rst = 0;
  logic [9:0] rd_addr = '0;
  logic [63:0] rd_data1, rd_data0;
  logic [1:0] pend1, pend0;
  logic wr_en = 0, iss_en = 0, clear_req = 0;
  logic [4:0] wr_addr = '0, iss_addr = '0;
  logic [31:0] wr_data = '0;
  logic ready1, ready0;
  int errors = 0, checks = 0;
  logic [31:0] m_regs [32];
  bit m_pend [32];
  bit m_busy = 1;
  int m_left = 31;
  bit armed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_pending(pend1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .clear_req(clear_req), .ready(ready1));
  regfile_sb #(.BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_pending(pend0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .clear_req(clear_req), .ready(ready0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; clear_req = 0;
  endtask

  task automatic tick();
    logic [4:0] a;
    logic [31:0] ed;
    bit ep;
    #1;
    if (armed) begin
      chk("ready1", 32'(ready1), 32'(!m_busy));
      chk("ready0", 32'(ready0), 32'(!m_busy));
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++) begin
          a = rd_addr[p*5 +: 5];
          if (m_busy || a == 0) begin ed = 0; ep = 0; end
          else if (b == 1 && wr_en && wr_addr == a) begin ed = wr_data; ep = 0; end
          else begin ed = m_regs[a]; ep = m_pend[a]; end
          chk($sformatf("data%0d_byp%0d", p, b), b ? rd_data1[p*32 +: 32] : rd_data0[p*32 +: 32], ed);
          chk($sformatf("pend%0d_byp%0d", p, b), 32'(b ? pend1[p] : pend0[p]), 32'(ep));
        end
    end
    @(posedge clk);
    if (!rst) begin
      m_busy = 1; m_left = 31;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else if (m_busy) begin
      m_regs[32 - m_left] = 0;
      m_left--;
      if (m_left == 0) m_busy = 0;
    end else if (clear_req) begin
      m_busy = 1; m_left = 31;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      if (wr_en && wr_addr != 0) begin m_regs[wr_addr] = wr_data; m_pend[wr_addr] = 0; end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1;
    end
    armed = 1;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input int pulse_at, input int exp);
    int n = 0;
    while (!ready1 && n < 100) begin
      idle();
      clear_req = (n == pulse_at);
      wr_en = clear_req; wr_addr = 5'd9; wr_data = 32'h33;
      tick();
      n++;
    end
    idle();
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic peek(input string tag, input int port, input logic [4:0] a,
                      input logic [31:0] ed, input bit ep);
    rd_addr[port*5 +: 5] = a;
    #1;
    chk({tag, "_d"}, rd_data1[port*32 +: 32], ed);
    chk({tag, "_p"}, 32'(pend1[port]), 32'(ep));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
    @(negedge clk);
    rst = 0; tick(); tick();
    rst = 1;
    chk("rst_ready", 32'(ready1), 0);
    wait_ready("clr_len", -1, 31);
    // write/read and x0
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; tick(); idle();
    peek("x5", 0, 5, 32'hDEADBEEF, 0); tick();
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; tick(); idle();
    peek("x0", 0, 0, 0, 0); tick();
    // bypass
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    peek("byp", 1, 7, 32'hA5A5A5A5, 0);
    chk("nobyp", rd_data0[63:32], 32'h0);
    tick(); idle();
    // scoreboard
    iss_en = 1; iss_addr = 3; tick(); idle();
    peek("iss3", 0, 3, 0, 1); tick();
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; tick(); idle();
    peek("wb3", 0, 3, 32'h55, 0); tick();
    iss_en = 1; iss_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h66; tick(); idle();
    peek("both3", 0, 3, 32'h66, 1); tick();
    iss_en = 1; iss_addr = 3; tick(); idle();
    wr_en = 1; wr_addr = 3; wr_data = 32'h67; tick(); idle();
    peek("nocount3", 0, 3, 32'h67, 0); tick();
    // clear request drops concurrent write and is not extended by a mid-sweep pulse
    wr_en = 1; wr_addr = 9; wr_data = 32'h11; tick(); idle();
    clear_req = 1; wr_en = 1; wr_addr = 9; wr_data = 32'h22; iss_en = 1; iss_addr = 9; tick(); idle();
    chk("clr_drop_ready", 32'(ready1), 0);
    wait_ready("clr_req_len", 10, 31);
    peek("x9clr", 0, 9, 0, 0); tick();
    // reset mid-sweep restarts the sweep and empties the scoreboard
    iss_en = 1; iss_addr = 4; tick(); idle();
    peek("iss4", 1, 4, 0, 1);
    clear_req = 1; tick(); idle();
    for (int i = 0; i < 10; i++) tick();
    rst = 0; tick(); rst = 1;
    wait_ready("rst_mid_len", -1, 31);
    peek("x4after", 1, 4, 0, 0); tick();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      clear_req = ($urandom_range(0, 79) == 0);
      wr_en = $urandom_range(0, 1); wr_addr = 5'($urandom_range(0, 7));
      wr_data = $urandom;
      iss_en = $urandom_range(0, 1); iss_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) == 0) rd_addr[4:0] = 5'($urandom_range(0, 31));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
